baud_frame_timer: RTL and testbench

- Parametrised successor to the fixed-divisor baud tick counter used by the XBee UART TX path on Nexys3.
- Generates one-cycle bit-period ticks from a runtime-loadable divisor.
- Has a TX mode (first tick one full period after start) and an RX mode (first tick mid-period, for sampling at bit centre).
- Counts ticks over a frame of FRAME_BITS bits, reporting bit index, busy and done; serves both the serial transmitter and a future receiver.

---
 rtl/baud_frame_timer.sv | 99 +++++++++
 tb/tb_baud_frame_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/baud_frame_timer.sv
// rtl/baud_frame_timer.sv - runtime-divisor bit-period tick generator with TX/RX alignment and frame counting
module baud_frame_timer #(
  parameter int DIV_W       = 14,
  parameter int DEFAULT_DIV = 10416,
  parameter int FRAME_BITS  = 10,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_mode,
  input  logic             start,
  input  logic             abort,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             busy,
  output logic             bit_tick,
  output logic [IDX_W-1:0] bit_idx,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] divisor, divisor_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] div_eff;
  logic [IDX_W-1:0] idx_next;
  logic             tick_next, done_next;

  // A coincident load and start must already use the new divisor.
  assign div_eff = div_load ? div_in : divisor;
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !abort) state_next = RUN;
      RUN:  if (abort || done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    divisor_next = divisor;
    cnt_next     = cnt;
    idx_next     = bit_idx;
    tick_next    = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (div_load) divisor_next = div_eff;
        if (start && !abort) begin
          idx_next = '0;
          // RX preloads the counter so the first match lands at bit centre.
          cnt_next = rx_mode ? (div_eff - (div_eff >> 1)) : '0;
        end
      end
      RUN: begin
        if (abort || done) begin
          cnt_next = '0;
        end else if (cnt == divisor) begin
          cnt_next  = '0;
          tick_next = 1'b1;
          idx_next  = bit_idx + 1'b1;
          done_next = (bit_idx == IDX_W'(FRAME_BITS - 1));
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DIV_W'(DEFAULT_DIV);
      cnt      <= '0;
      bit_idx  <= '0;
      bit_tick <= 1'b0;
      done     <= 1'b0;
    end else begin
      divisor  <= divisor_next;
      cnt      <= cnt_next;
      bit_idx  <= idx_next;
      bit_tick <= tick_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_baud_frame_timer.sv
// tb/tb_baud_frame_timer.sv - scoreboard bench for baud_frame_timer
module tb_baud_frame_timer;
  localparam int DIV_W = 14;
  localparam int FRAME_BITS = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_mode = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             busy, bit_tick, done;
  logic [IDX_W-1:0] bit_idx;

  baud_frame_timer #(.DIV_W(DIV_W), .DEFAULT_DIV(10416), .FRAME_BITS(FRAME_BITS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .rx_mode(rx_mode), .start(start), .abort(abort),
    .div_load(div_load), .div_in(div_in), .busy(busy), .bit_tick(bit_tick),
    .bit_idx(bit_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int idx; bit dn;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit prev_done = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected tick k is visible at the negedge where cyc = s + 1 + first + (k-1)*(d+1).
  task automatic push_frame(input int s, input int d, input bit rx, input int n);
    int first;
    exp_t e;
    first = rx ? (d >> 1) + 1 : d + 1;
    for (int k = 1; k <= n; k++) begin
      e.cyc = s + 1 + first + (k - 1) * (d + 1);
      e.idx = k;
      e.dn  = (k == FRAME_BITS);
      q.push_back(e);
    end
  endtask

  task automatic load_div(input int d);
    @(negedge clk);
    div_load = 1'b1;
    div_in = DIV_W'(d);
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic do_start(input bit rx, input int d, input bit with_load, input int n, output int s);
    @(negedge clk);
    rx_mode = rx;
    start = 1'b1;
    div_load = with_load;
    div_in = DIV_W'(d);
    s = cyc;
    push_frame(s, d, rx, n);
    @(negedge clk);
    start = 1'b0;
    div_load = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < budget);
    chk(!busy && q.size() == 0, name, q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) begin
      chk(busy == 1'b0, "busy_after_done", int'(busy), 0);
      chk(bit_tick == 1'b0, "tick_after_done", int'(bit_tick), 0);
    end
    prev_done = 1'b0;
    if (done && !bit_tick) chk(1'b0, "done_without_tick", 1, 0);
    if (bit_tick) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_tick", int'(bit_idx), 0);
      end else begin
        e = q.pop_front();
        chk(cyc == e.cyc && int'(bit_idx) == e.idx && done == e.dn, "tick_cycle_idx_done",
            cyc * 100 + int'(bit_idx) * 10 + int'(done), e.cyc * 100 + e.idx * 10 + int'(e.dn));
        prev_done = done;
      end
    end
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(bit_tick == 1'b0, "reset_tick", int'(bit_tick), 0);
    chk(done == 1'b0, "reset_done", int'(done), 0);
    chk(bit_idx == 0, "reset_idx", int'(bit_idx), 0);

    // TX, div 9
    load_div(9);
    do_start(1'b0, 9, 1'b0, FRAME_BITS, s);
    wait_idle(200, "tx9_frame_end");
    chk(bit_idx == 4'd10, "tx9_idx_hold", int'(bit_idx), 10);

    // RX, div 9 then div 8
    do_start(1'b1, 9, 1'b0, FRAME_BITS, s);
    wait_idle(200, "rx9_frame_end");
    load_div(8);
    do_start(1'b1, 8, 1'b0, FRAME_BITS, s);
    wait_idle(200, "rx8_frame_end");

    // Load and start ignored while busy, start in done cycle ignored
    load_div(9);
    do_start(1'b0, 9, 1'b0, FRAME_BITS, s);
    repeat (15) @(negedge clk);
    div_load = 1'b1; div_in = 3; start = 1'b1;
    @(negedge clk);
    div_load = 1'b0; start = 1'b0;
    wait_cyc(s + 1 + 10 * FRAME_BITS);
    chk(done == 1'b1, "done_cycle_seen", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(busy == 1'b0, "start_in_done_ignored", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "still_idle", int'(busy), 0);
    do_start(1'b0, 9, 1'b0, FRAME_BITS, s);
    wait_idle(200, "div_kept_9_frame_end");

    // Coincident load and start
    do_start(1'b0, 4, 1'b1, FRAME_BITS, s);
    wait_idle(200, "load_start_frame_end");

    // Abort on the cycle the 5th tick is due
    load_div(9);
    do_start(1'b0, 9, 1'b0, 4, s);
    wait_cyc(s + 1 + 10 * 5 - 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(busy == 1'b0, "abort_busy", int'(busy), 0);
    chk(bit_idx == 4'd4, "abort_idx", int'(bit_idx), 4);
    repeat (15) @(negedge clk);
    chk(q.size() == 0, "abort_queue", q.size(), 0);

    // Abort with start in IDLE
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk(busy == 1'b0, "abort_start_idle", int'(busy), 0);

    // Divisor 0
    load_div(0);
    do_start(1'b0, 0, 1'b0, FRAME_BITS, s);
    wait_idle(50, "div0_frame_end");

    // Reset mid-frame restores default divisor
    load_div(9);
    do_start(1'b0, 9, 1'b0, 3, s);
    wait_cyc(s + 35);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(busy == 1'b0 && bit_tick == 1'b0 && done == 1'b0, "rst_mid_outputs",
        int'(busy) + int'(bit_tick) + int'(done), 0);
    chk(bit_idx == 0, "rst_mid_idx", int'(bit_idx), 0);
    do_start(1'b0, 10416, 1'b0, 2, s);
    wait_cyc(s + 1 + 10417 * 2 + 3);
    chk(q.size() == 0, "default_div_ticks", q.size(), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(busy == 1'b0, "default_abort_busy", int'(busy), 0);
    chk(bit_idx == 4'd2, "default_abort_idx", int'(bit_idx), 2);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
